// File: rtl/inst_pointer_stack_pkg.sv
// Shared helpers for the instruction-pointer block and its return-address stack.
package inst_pointer_stack_pkg;

    // Ceiling log2. Used to size counters that must hold the value n - 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ip_return_stack.sv
// LIFO of return addresses. The top entry is readable combinationally.
// A push while full and a pop while empty are both ignored.
module ip_return_stack
    import inst_pointer_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned LW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    top_idx;
    logic             pop_en;
    logic             push_en;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign top_idx = level_q - LW'(1);
    assign dout    = empty ? '0 : mem_q[top_idx[IW-1:0]];

    // A valid pop takes precedence over a simultaneous push.
    assign pop_en  = pop && !empty;
    assign push_en = push && !full && !pop_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else if (pop_en) begin
            level_q <= level_q - LW'(1);
        end else if (push_en) begin
            level_q <= level_q + LW'(1);
        end
    end

    // Entries carry no reset: their contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            mem_q[level_q[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/inst_pointer_stack.sv
// Program counter with jump, signed relative branch and call/return through
// an internal return-address stack. Freeze holds all state.
module inst_pointer_stack
    import inst_pointer_stack_pkg::*;
#(
    parameter int unsigned           PC_WIDTH     = 8,
    parameter int unsigned           OFF_WIDTH    = 8,
    parameter int unsigned           STEP         = 1,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int unsigned           STACK_DEPTH  = 4,
    localparam int unsigned          SPW          = clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 jump,
    input  logic                 call,
    input  logic                 ret,
    input  logic                 branch,
    input  logic [PC_WIDTH-1:0]  target,
    input  logic [OFF_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [SPW-1:0]       sp_level,
    output logic                 stack_full,
    output logic                 stack_empty,
    output logic                 overflow,
    output logic                 underflow
);

    logic [PC_WIDTH-1:0]         pc_q, pc_d;
    logic [PC_WIDTH-1:0]         pc_next_seq;
    logic [PC_WIDTH-1:0]         off_ext;
    logic signed [OFF_WIDTH-1:0] off_s;
    logic [PC_WIDTH-1:0]         stack_top;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;
    logic                        do_ret, do_call;

    assign off_s       = offset;
    assign off_ext     = PC_WIDTH'(off_s);
    assign pc_next_seq = pc_q + PC_WIDTH'(STEP);

    // ret outranks call, so a call only counts when ret is low.
    assign do_ret  = !freeze && ret;
    assign do_call = !freeze && !ret && call;

    ip_return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (do_call),
        .pop   (do_ret),
        .din   (pc_next_seq),
        .dout  (stack_top),
        .level (sp_level),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_d        = pc_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (!freeze) begin
            if (ret) begin
                if (stack_empty) begin
                    pc_d        = pc_next_seq;
                    underflow_d = 1'b1;
                end else begin
                    pc_d = stack_top;
                end
            end else if (call) begin
                pc_d = target;
                if (stack_full) begin
                    overflow_d = 1'b1;
                end
            end else if (jump) begin
                pc_d = target;
            end else if (branch) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_next_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pc        = pc_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_inst_pointer_stack.sv
// Scoreboard bench: two configurations share one command stream; a queue-based
// reference model predicts each post-edge state and a monitor checks it.
module tb_inst_pointer_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b1, freeze = 1'b0, jump = 1'b0, call = 1'b0;
    logic        ret = 1'b0, branch = 1'b0;
    logic [15:0] target = '0;
    logic [7:0]  offset = '0;
    logic [7:0]  target8;

    logic [7:0]  pc0;
    logic [2:0]  lvl0;
    logic        full0, empty0, ovf0, unf0;
    logic [15:0] pc1;
    logic [2:0]  lvl1;
    logic        full1, empty1, ovf1, unf1;

    assign target8 = target[7:0];

    always #5 clk = ~clk;

    inst_pointer_stack dut0 (
        .clk (clk), .rst (rst), .freeze (freeze), .jump (jump), .call (call),
        .ret (ret), .branch (branch), .target (target8), .offset (offset),
        .pc (pc0), .sp_level (lvl0), .stack_full (full0), .stack_empty (empty0),
        .overflow (ovf0), .underflow (unf0)
    );

    inst_pointer_stack #(
        .PC_WIDTH (16), .OFF_WIDTH (8), .STEP (4), .RESET_VECTOR (16'h0100),
        .STACK_DEPTH (4)
    ) dut1 (
        .clk (clk), .rst (rst), .freeze (freeze), .jump (jump), .call (call),
        .ret (ret), .branch (branch), .target (target), .offset (offset),
        .pc (pc1), .sp_level (lvl1), .stack_full (full1), .stack_empty (empty1),
        .overflow (ovf1), .underflow (unf1)
    );

    // Reference model: both configurations see identical commands with equal
    // depth, so the stack holds a pair of return addresses per entry.
    typedef struct { int a0; int a1; } pair_t;
    typedef struct { int pc0; int pc1; int lvl; bit ovf; bit unf; } exp_t;

    pair_t stk[$];
    exp_t  exp_q[$];
    int    m_pc0 = 0, m_pc1 = 0;
    bit    m_ovf = 0, m_unf = 0;
    int    n_cmp = 0, n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cyc(input bit r, input bit f, input bit j, input bit c, input bit rt,
                       input bit b, input logic [15:0] t, input logic [7:0] o);
        pair_t p;
        exp_t  e;
        int    s;
        @(negedge clk);
        rst = r; freeze = f; jump = j; call = c; ret = rt; branch = b;
        target = t; offset = o;
        s = int'($signed(o));
        if (r) begin
            m_pc0 = 0; m_pc1 = 'h100; stk.delete(); m_ovf = 0; m_unf = 0;
        end else if (f) begin
            // state holds
        end else if (rt) begin
            if (stk.size() > 0) begin
                p = stk.pop_back();
                m_pc0 = p.a0; m_pc1 = p.a1;
            end else begin
                m_pc0 = (m_pc0 + 1) & 'hFF; m_pc1 = (m_pc1 + 4) & 'hFFFF; m_unf = 1;
            end
        end else if (c) begin
            if (stk.size() < 4) begin
                p.a0 = (m_pc0 + 1) & 'hFF; p.a1 = (m_pc1 + 4) & 'hFFFF;
                stk.push_back(p);
            end else begin
                m_ovf = 1;
            end
            m_pc0 = int'(t) & 'hFF; m_pc1 = int'(t);
        end else if (j) begin
            m_pc0 = int'(t) & 'hFF; m_pc1 = int'(t);
        end else if (b) begin
            m_pc0 = (m_pc0 + s) & 'hFF; m_pc1 = (m_pc1 + s) & 'hFFFF;
        end else begin
            m_pc0 = (m_pc0 + 1) & 'hFF; m_pc1 = (m_pc1 + 4) & 'hFFFF;
        end
        e.pc0 = m_pc0; e.pc1 = m_pc1; e.lvl = stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic seq();
        cyc(0, 0, 0, 0, 0, 0, 16'h0, 8'h0);
    endtask

    // Monitor: outputs are registered and valid every cycle; check just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc0", 32'(pc0), 32'(e.pc0));
                chk("lvl0", 32'(lvl0), 32'(e.lvl));
                chk("full0", 32'(full0), 32'(e.lvl == 4));
                chk("empty0", 32'(empty0), 32'(e.lvl == 0));
                chk("ovf0", 32'(ovf0), 32'(e.ovf));
                chk("unf0", 32'(unf0), 32'(e.unf));
                chk("pc1", 32'(pc1), 32'(e.pc1));
                chk("lvl1", 32'(lvl1), 32'(e.lvl));
                chk("full1", 32'(full1), 32'(e.lvl == 4));
                chk("empty1", 32'(empty1), 32'(e.lvl == 0));
                chk("ovf1", 32'(ovf1), 32'(e.ovf));
                chk("unf1", 32'(unf1), 32'(e.unf));
            end
        end
    end

    initial begin
        bit r, f, j, c, rt, b;
        // Reset then free-running count.
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
        repeat (3) seq();
        // Reset while running from 0x57.
        cyc(0, 0, 1, 0, 0, 0, 16'h0057, 8'h0);
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
        // Call / return round trip.
        cyc(0, 0, 1, 0, 0, 0, 16'h0010, 8'h0);
        cyc(0, 0, 0, 1, 0, 0, 16'h0080, 8'h0);
        repeat (2) seq();
        cyc(0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
        // Negative branch and wrap.
        cyc(0, 0, 1, 0, 0, 0, 16'h0002, 8'h0);
        cyc(0, 0, 0, 0, 0, 1, 16'h0, 8'hFC);
        repeat (2) seq();
        // Overflow then underflow.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 16'(16'h0020 + i * 16), 8'h0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 16'h0, 8'h0);
        // Priority with one entry 0x33 on the stack, then freeze over a call.
        cyc(1, 0, 0, 0, 0, 0, 16'h0, 8'h0);
        cyc(0, 0, 1, 0, 0, 0, 16'h0032, 8'h0);
        cyc(0, 0, 0, 1, 0, 0, 16'h0040, 8'h0);
        cyc(0, 0, 1, 1, 1, 0, 16'h0099, 8'h0);
        repeat (3) cyc(0, 1, 0, 1, 0, 0, 16'h0077, 8'h0);
        seq();
        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 9) == 0);
            rt = ($urandom_range(0, 4) == 0);
            c  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 3) == 0);
            cyc(r, f, j, c, rt, b, 16'($urandom), 8'($urandom));
        end
        seq();
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_pointer_stack.md
Name: inst_pointer_stack

Overview:
- Parametrised successor to the 8-bit free-running instruction pointer of the RISC processor.
- Holds the program counter (PC) with configurable width, increment step and reset vector.
- Supports absolute jump, signed relative branch, and call/return through an internal LIFO return-address stack of configurable depth.
- Sits between the decode/branch unit and the instruction memory address port. Freeze stalls it for pipeline hazards.

Parameters:
- PC_WIDTH, 8, PC and address width in bits.
- OFF_WIDTH, 8, width of the signed relative-branch offset (OFF_WIDTH <= PC_WIDTH).
- STEP, 1, sequential increment per unfrozen cycle.
- RESET_VECTOR, 0, PC value after reset.
- STACK_DEPTH, 4, number of return-address entries (>= 2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  holds PC and stack unchanged; overrides every command.
- jump  in  1  load PC from target.
- call  in  1  load PC from target; push PC+STEP.
- ret  in  1  load PC from top of stack; pop.
- branch  in  1  PC <= PC + sign-extended offset.
- target  in  PC_WIDTH  absolute destination for jump/call.
- offset  in  OFF_WIDTH  two's-complement branch displacement.
- pc  out  PC_WIDTH  current instruction address (registered).
- sp_level  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  out  1  sp_level == STACK_DEPTH.
- stack_empty  out  1  sp_level == 0.
- overflow  out  1  sticky: call issued while full.
- underflow  out  1  sticky: ret issued while empty.

Behaviour:
- Reset (sync, active-high): pc = RESET_VECTOR; sp_level = 0; stack_empty = 1; stack_full = 0; overflow = 0; underflow = 0. Stack contents are don't-care.
- Reset wins over freeze and over all commands. Reset mid-call or mid-ret discards the stack.
- Latency: a command sampled at edge N makes pc show the new value after edge N. There are no bubbles.
- freeze = 1: pc, stack, sp_level and the sticky flags all hold. Commands in that cycle are ignored, not queued.
- Command priority when more than one is asserted (unfrozen): ret > call > jump > branch > sequential. Only the winning command has any effect.
- ret, stack not empty: pc <= top entry; sp_level decrements.
- ret, stack empty: pc <= pc + STEP; underflow <= 1; sp_level stays 0.
- call, stack not full: push (pc + STEP) mod 2^PC_WIDTH; pc <= target; sp_level increments.
- call, stack full: pc <= target; no push, oldest entries preserved; overflow <= 1.
- jump: pc <= target.
- branch: pc <= (pc + sign_extend(offset)) mod 2^PC_WIDTH.
- None asserted: pc <= (pc + STEP) mod 2^PC_WIDTH.
- Wrap-around: all PC arithmetic is modulo 2^PC_WIDTH with no flag. Example: PC_WIDTH=8, pc=0xFF, STEP=1 gives 0x00.
- stack_full and stack_empty are derived combinationally from registered sp_level (glitch-free relative to clk).
- Sticky flags clear only on rst.

Decomposition:
- Shared package holds clog2 helper function only. No typedefs; command inputs stay as discrete strobes.
- One sub-module: ip_return_stack.
  - Ports: clk, rst, push, pop, din, dout (top, combinational read), level, full, empty.
  - Parameters: WIDTH, DEPTH.
  - Register array plus pointer; ignores push when full and pop when empty.
  - Overflow/underflow detection stays in the top level.

Test Plan:
- Reset then 3 free cycles (defaults) -> pc = 0x00, 0x01, 0x02, 0x03. Hold rst with pc=0x57 -> pc = 0x00 next edge, sp_level = 0, flags 0.
- pc=0x10, call target=0x80; then 2 sequential cycles; then ret -> pc = 0x80, 0x81, 0x82, 0x11; sp_level 1 then 0.
- branch offset=0xFC (-4) at pc=0x02 -> pc = 0xFE. Then sequential twice -> 0xFF, 0x00 (wrap, no flag).
- DEPTH=4: 5 nested calls -> overflow = 1, stack_full = 1, sp_level = 4. Then 5 rets -> 4 correct return addresses, then fifth gives pc+1 and underflow = 1.
- call+ret+jump asserted together with 1 entry (0x33) on stack -> pc = 0x33, sp_level 0, no push. freeze=1 with call asserted -> pc and sp_level unchanged for every frozen cycle.
- STEP=4, PC_WIDTH=16, RESET_VECTOR=0x0100 -> pc after reset 0x0100, then 0x0104. Call pushes pc+4.
